// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer: run-handshake FSM state
// type, decode-mode encodings and a helper that maps the deprecated NOP
// mode onto the plain register mode.
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_TGT = 2'b01;
  localparam logic [1:0] MODE_IMM = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  // Older decoders still emit MODE_NOP; it behaves exactly like MODE_REG.
  function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
    return (mode == MODE_NOP) ? MODE_REG : mode;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
// Program counter register with a prioritised update:
//   Load (absolute) > Rel (add unsigned offset) > Inc (+1) > hold.
// Arithmetic wraps modulo 2**PC_W without any indication.
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   synchronous active-high, loads START_ADDR
//   Load     in   load LoadVal
//   LoadVal  in   PC_W   absolute value
//   Rel      in   add RelOff
//   RelOff   in   9      unsigned relative offset
//   Inc      in   advance by one
//   ProgCtr  out  PC_W   current program counter
// ---------------------------------------------------------------------------
module prog_counter
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Load,
  input  logic [PC_W-1:0] LoadVal,
  input  logic            Rel,
  input  logic [8:0]      RelOff,
  input  logic            Inc,
  output logic [PC_W-1:0] ProgCtr
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ProgCtr <= START_ADDR;
    end else if (Load) begin
      ProgCtr <= LoadVal;
    end else if (Rel) begin
      ProgCtr <= ProgCtr + PC_W'(RelOff);
    end else if (Inc) begin
      ProgCtr <= ProgCtr + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Architectural sequencing state around the combinational decoder: program
// counter, decode mode, previous instruction word, compare flags and the
// Req/Done run handshake. Run gates every write enable at the top level.
//
// Optional feature: define SEQ_CYCLE_CNT_EN to build the saturating
// executed-cycle counter; otherwise CycleCount is tied to zero.
//
// Ports:
//   Clk              in   rising-edge clock
//   Reset            in   synchronous active-high
//   Req              in   start request
//   Instruction      in   9     ROM word at ProgCtr
//   NextState        in   2     decoder next decode mode
//   BranchEn         in   relative branch request
//   BranchTarget     in   9     unsigned relative offset
//   CMPLoadEn        in   capture CMPIn
//   CMPIn            in   3     {zero, equal, gt}
//   AckIn            in   end of program
//   ProgCtr          out  PC_W  ROM address
//   CurrState        out  2     decode mode
//   PrevInstruction  out  9     previous instruction word
//   CMPBits          out  3     registered compare flags
//   Run              out  executing
//   Done             out  program finished
//   CycleCount       out  16    executed-cycle count
//
// state    | meaning
// ---------+-----------------------------------------------
// SEQ_IDLE | after reset, waiting for Req
// SEQ_RUN  | executing one ROM word per cycle until AckIn
// SEQ_DONE | program finished, Done=1, waiting for Req
// ---------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Req,
  input  logic [8:0]      Instruction,
  input  logic [1:0]      NextState,
  input  logic            BranchEn,
  input  logic [8:0]      BranchTarget,
  input  logic            CMPLoadEn,
  input  logic [2:0]      CMPIn,
  input  logic            AckIn,
  output logic [PC_W-1:0] ProgCtr,
  output logic [1:0]      CurrState,
  output logic [8:0]      PrevInstruction,
  output logic [2:0]      CMPBits,
  output logic            Run,
  output logic            Done,
  output logic [15:0]     CycleCount
);

  seq_state_t      state;
  logic            in_run;
  logic            start_run;
  logic            step;
  logic            tgt_word;
  logic            pc_load;
  logic            pc_rel;
  logic            pc_inc;
  logic [PC_W-1:0] pc_load_val;

  assign in_run    = (state == SEQ_RUN);
  assign start_run = !in_run && Req;
  // A normal execute step; the Ack word freezes the PC.
  assign step      = in_run && !AckIn;
  // Word following a branch opcode (bit 8 set) in target mode is an absolute address.
  assign tgt_word  = (CurrState == MODE_TGT) && PrevInstruction[8];

  assign pc_load     = start_run || (step && tgt_word);
  assign pc_load_val = start_run ? START_ADDR : PC_W'(Instruction);
  assign pc_rel      = step && !tgt_word && BranchEn;
  assign pc_inc      = step && !tgt_word && !BranchEn;

  prog_counter #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_prog_counter (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (pc_load),
    .LoadVal (pc_load_val),
    .Rel     (pc_rel),
    .RelOff  (BranchTarget),
    .Inc     (pc_inc),
    .ProgCtr (ProgCtr)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= SEQ_IDLE;
      CurrState       <= MODE_REG;
      PrevInstruction <= '0;
      CMPBits         <= '0;
      Run             <= 1'b0;
      Done            <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE, SEQ_DONE: begin
          if (Req) begin
            state           <= SEQ_RUN;
            CurrState       <= MODE_REG;
            PrevInstruction <= '0;
            CMPBits         <= '0;
            Run             <= 1'b1;
            Done            <= 1'b0;
          end
        end
        SEQ_RUN: begin
          PrevInstruction <= Instruction;
          // New flags become visible next cycle; this cycle's branch saw the old ones.
          if (CMPLoadEn) begin
            CMPBits <= CMPIn;
          end
          if (AckIn) begin
            state     <= SEQ_DONE;
            CurrState <= MODE_REG;
            Run       <= 1'b0;
            Done      <= 1'b1;
          end else begin
            CurrState <= sanitize_mode(NextState);
          end
        end
        default: begin
          state <= SEQ_IDLE;
          Run   <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_cnt <= '0;
    end else if (start_run) begin
      cycle_cnt <= '0;
    end else if (in_run && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  assign CycleCount = cycle_cnt;
`else
  assign CycleCount = 16'h0000;
`endif

endmodule
